// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mdu_pkg                                                    |
// | Description : Shared types and constants for the RV32M multiply/divide   |
// |               sequencer: funct3 op encoding, sequencer states, widths.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mdu_pkg;

  localparam int          XLEN      = 32;
  localparam int          DPW       = 33;
  localparam logic [31:0] DIV_OVF_Q = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_FIX   = 3'd4,
    S_RESP  = 3'd5,
    S_DRAIN = 3'd6
  } mdu_state_e;

  // funct3[2] set selects the divide family.
  function automatic logic is_div_op(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Quotient-producing ops (DIV/DIVU) as opposed to remainder ops.
  function automatic logic is_quot_op(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_result_fix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mdu_result_fix                                             |
// | Description : Combinational result selection from the datapath outputs   |
// |               and quotient/remainder sign correction.                    |
// | Ports       : op      - latched funct3                                   |
// |               aval    - datapath high half / remainder                   |
// |               bval    - datapath low half / quotient                     |
// |               neg_q   - negate quotient                                  |
// |               neg_r   - negate remainder                                 |
// |               result  - 32-bit architectural result                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mdu_result_fix
  import mdu_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [DPW-1:0]  aval,
  input  logic [DPW-1:0]  bval,
  input  logic            neg_q,
  input  logic            neg_r,
  output logic [XLEN-1:0] result
);

  // Product bit 65 and remainder bit 32 never reach a 32-bit result.
  logic w_unused;
  assign w_unused = aval[DPW-1];

  always_comb begin
    result = '0;
    case (op)
      OP_MUL:                       result = bval[XLEN-1:0];
      // Product bits [63:32] straddle the two 33-bit halves.
      OP_MULH, OP_MULHSU, OP_MULHU: result = {aval[XLEN-2:0], bval[XLEN]};
      OP_DIV, OP_DIVU:              result = neg_q ? -bval[XLEN-1:0] : bval[XLEN-1:0];
      OP_REM, OP_REMU:              result = neg_r ? -aval[XLEN-1:0] : aval[XLEN-1:0];
      default:                      result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mdu_sequencer                                              |
// | Description : Sequencer for the shared 33-bit multiply/divide datapath.  |
// |               Decodes RV32M funct3, conditions operands, runs the        |
// |               datapath, fixes result signs, and short-circuits           |
// |               divide-by-zero and signed overflow.                        |
// | Ports       : Clk, Reset_n (async, active low)                           |
// |               req_valid/req_ready, funct3, rs1, rs2 - request            |
// |               kill - abort in-flight op                                  |
// |               resp_valid/resp_ready, resp_data     - response            |
// |               dp_run, dp_div, dp_opA, dp_opB       - to datapath         |
// |               dp_Aval, dp_Bval, dp_ready           - from datapath       |
// | Config      : MDU_OPCACHE_EN - one-entry result cache                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            dp_run,
  output logic            dp_div,
  output logic [DPW-1:0]  dp_opA,
  output logic [DPW-1:0]  dp_opB,
  input  logic [DPW-1:0]  dp_Aval,
  input  logic [DPW-1:0]  dp_Bval,
  input  logic            dp_ready
);

  mdu_state_e      r_state, w_state_nxt;
  mdu_op_e         r_op, w_req_op;
  logic [XLEN-1:0] r_rs1, r_rs2, r_resp_data;
  logic            r_neg_q, r_neg_r, r_wait_first, r_alive, r_dp_div;
  logic [DPW-1:0]  r_dp_opA, r_dp_opB, w_opA, w_opB;
  logic            w_s1, w_s2, w_accept;
  logic            w_byp_zero, w_byp_ovf, w_bypass, w_cache_hit;
  logic [XLEN-1:0] w_byp_result, w_cache_result, w_fix_result;

  assign w_req_op = mdu_op_e'(funct3);
  assign w_accept = req_valid && req_ready;
  assign w_s1     = rs1[XLEN-1];
  assign w_s2     = rs2[XLEN-1];

  // Operands are conditioned at accept so the datapath sees them stable
  // from PREP onward; signed divide uses magnitudes, and |INT_MIN| fits
  // as an unsigned 33-bit value.
  always_comb begin
    w_opA = {1'b0, rs1};
    w_opB = {1'b0, rs2};
    case (w_req_op)
      OP_MUL, OP_MULH: begin
        w_opA = {w_s1, rs1};
        w_opB = {w_s2, rs2};
      end
      OP_MULHSU: w_opA = {w_s1, rs1};
      OP_DIV, OP_REM: begin
        w_opA = {1'b0, (w_s1 ? -rs1 : rs1)};
        w_opB = {1'b0, (w_s2 ? -rs2 : rs2)};
      end
      default: ;
    endcase
  end

  // Divide-by-zero and INT_MIN/-1 never touch the datapath.
  assign w_byp_zero = is_div_op(r_op) && (r_rs2 == '0);
  assign w_byp_ovf  = is_signed_div(r_op) && (r_rs1 == DIV_OVF_Q) && (r_rs2 == {XLEN{1'b1}});
  assign w_bypass   = w_byp_zero || w_byp_ovf;

  always_comb begin
    w_byp_result = '0;
    if (w_byp_zero)
      w_byp_result = is_quot_op(r_op) ? {XLEN{1'b1}} : r_rs1;
    else if (w_byp_ovf)
      w_byp_result = is_quot_op(r_op) ? DIV_OVF_Q : '0;
  end

  mdu_result_fix u_result_fix (
    .op     (r_op),
    .aval   (dp_Aval),
    .bval   (dp_Bval),
    .neg_q  (r_neg_q),
    .neg_r  (r_neg_r),
    .result (w_fix_result)
  );

`ifdef MDU_OPCACHE_EN
  logic            r_c_valid;
  mdu_op_e         r_c_op;
  logic [XLEN-1:0] r_c_rs1, r_c_rs2, r_c_result;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_c_valid  <= 1'b0;
      r_c_op     <= OP_MUL;
      r_c_rs1    <= '0;
      r_c_rs2    <= '0;
      r_c_result <= '0;
    end else if (kill) begin
      r_c_valid  <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_c_valid  <= 1'b1;
      r_c_op     <= r_op;
      r_c_rs1    <= r_rs1;
      r_c_rs2    <= r_rs2;
      r_c_result <= w_fix_result;
    end
  end

  assign w_cache_hit    = r_c_valid && (r_c_op == r_op) && (r_c_rs1 == r_rs1) && (r_c_rs2 == r_rs2);
  assign w_cache_result = r_c_result;
`else
  assign w_cache_hit    = 1'b0;
  assign w_cache_result = '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_PREP;
      S_PREP: begin
        if (kill)                         w_state_nxt = S_IDLE;
        else if (w_bypass || w_cache_hit) w_state_nxt = S_RESP;
        else                              w_state_nxt = S_START;
      end
      S_START: w_state_nxt = kill ? S_IDLE : S_WAIT;
      // A killed op still owns the datapath until it reports done.
      S_WAIT: begin
        if (kill)                            w_state_nxt = S_DRAIN;
        else if (!r_wait_first && dp_ready)  w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = kill ? S_IDLE : S_RESP;
      S_RESP:  if (kill || resp_ready) w_state_nxt = S_IDLE;
      S_DRAIN: if (dp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op         <= OP_MUL;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_dp_div     <= 1'b0;
      r_dp_opA     <= '0;
      r_dp_opB     <= '0;
      r_wait_first <= 1'b0;
      r_resp_data  <= '0;
      r_alive      <= 1'b0;
    end else begin
      // Keeps req_ready low while reset is held even if the datapath is idle.
      r_alive      <= 1'b1;
      // dp_ready may still show the previous idle state in the first WAIT cycle.
      r_wait_first <= (r_state == S_START);
      if (w_accept) begin
        r_op     <= w_req_op;
        r_rs1    <= rs1;
        r_rs2    <= rs2;
        r_dp_opA <= w_opA;
        r_dp_opB <= w_opB;
        r_dp_div <= is_div_op(w_req_op);
        r_neg_q  <= is_signed_div(w_req_op) && (w_s1 ^ w_s2);
        r_neg_r  <= is_signed_div(w_req_op) && w_s1;
      end
      if (r_state == S_PREP && w_bypass)
        r_resp_data <= w_byp_result;
      else if (r_state == S_PREP && w_cache_hit)
        r_resp_data <= w_cache_result;
      else if (r_state == S_FIX)
        r_resp_data <= w_fix_result;
    end
  end

  assign req_ready  = r_alive && (r_state == S_IDLE) && dp_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign dp_run     = (r_state == S_START);
  assign dp_div     = r_dp_div;
  assign dp_opA     = r_dp_opA;
  assign dp_opB     = r_dp_opB;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mdu_sequencer                                           |
// | Description : Self-checking bench for mdu_sequencer with a behavioural   |
// |               multiply/divide datapath and an expected-result queue.     |
// | Config      : MDU_OPCACHE_EN - expects cache hits on repeated ops        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int DP_LAT = 6;

  logic        Clk = 1'b0, Reset_n = 1'b1;
  logic        req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        req_ready, resp_valid, dp_run, dp_div;
  logic [31:0] resp_data;
  logic [32:0] dp_opA, dp_opB;
  logic [32:0] dp_Aval = '0, dp_Bval = '0;
  logic        dp_ready = 1'b1;
  int          dp_cnt = 0;
  int          run_cnt = 0;
  int          checks = 0, failures = 0;
  logic [31:0] exp_q[$];

  always #5 Clk = ~Clk;

  mdu_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .dp_run(dp_run), .dp_div(dp_div), .dp_opA(dp_opA), .dp_opB(dp_opB),
    .dp_Aval(dp_Aval), .dp_Bval(dp_Bval), .dp_ready(dp_ready)
  );

  // Behavioural datapath: signed 33x33 multiply or unsigned 33-bit divide,
  // busy for DP_LAT cycles; not reset by the sequencer's reset.
  always @(posedge Clk) begin : dp_model
    logic [65:0] prod;
    if (dp_run) run_cnt <= run_cnt + 1;
    if (dp_run && dp_ready) begin
      dp_ready <= 1'b0;
      dp_cnt   <= DP_LAT;
      if (dp_div) begin
        dp_Bval <= (dp_opB != 0) ? dp_opA / dp_opB : '1;
        dp_Aval <= (dp_opB != 0) ? dp_opA % dp_opB : dp_opA;
      end else begin
        prod = {{33{dp_opA[32]}}, dp_opA} * {{33{dp_opB[32]}}, dp_opB};
        {dp_Aval, dp_Bval} <= prod;
      end
    end else if (!dp_ready) begin
      if (dp_cnt <= 1) dp_ready <= 1'b1;
      else             dp_cnt   <= dp_cnt - 1;
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural RV32M reference.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b};                   return p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};       return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};             return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};                   return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic wait_req_ready(output logic ok);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge Clk); n++; end
    ok = req_ready;
    if (!ok) check_val("req_ready_timeout", 1'b0, 1'b1);
  endtask

  // One request/response. exp_lat / exp_runs < 0 skip those checks.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input int exp_lat, input int exp_runs);
    int n, runs0;
    logic ok;
    logic [31:0] exp, held;
    string tag;
    tag = $sformatf("op%0d_%h_%h", op, a, b);
    wait_req_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; funct3 = op; rs1 = a; rs2 = b;
    exp_q.push_back(ref_result(op, a, b));
    runs0 = run_cnt;
    @(negedge Clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 200) begin @(negedge Clk); n++; end
    exp = exp_q.pop_front();
    if (!resp_valid) begin
      check_val({tag, "_resp_timeout"}, 1'b0, 1'b1);
      return;
    end
    check_val({tag, "_data"}, resp_data, exp);
    if (exp_lat >= 0)  check_val({tag, "_latency"}, n, exp_lat);
    if (exp_runs >= 0) check_val({tag, "_dp_runs"}, run_cnt - runs0, exp_runs);
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check_val({tag, "_hold"}, {resp_valid, req_ready, resp_data}, {1'b1, 1'b0, held});
    end
    resp_ready = 1'b1;
    @(negedge Clk);
    resp_ready = 1'b0;
    check_val({tag, "_resp_drop"}, resp_valid, 1'b0);
  endtask

  task automatic kill_test();
    logic ok, bad;
    int n;
    wait_req_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; funct3 = OP_DIVU; rs1 = 32'hDEAD_BEEF; rs2 = 32'h13;
    @(negedge Clk); req_valid = 1'b0;   // PREP
    @(negedge Clk);                     // START
    @(negedge Clk);                     // WAIT
    kill = 1'b1;
    @(negedge Clk);
    kill = 1'b0;
    bad = 1'b0;
    n = 0;
    while (!dp_ready && n < 100) begin
      if (req_ready || resp_valid) bad = 1'b1;
      @(negedge Clk);
      n++;
    end
    check_val("kill_quiet_while_busy", bad, 1'b0);
    check_val("kill_drain_still_busy", {req_ready, resp_valid}, 2'b00);
    @(negedge Clk);
    check_val("kill_drain_to_idle", {req_ready, resp_valid}, 2'b10);
  endtask

  task automatic reset_test();
    logic ok;
    wait_req_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; funct3 = OP_DIV; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge Clk); req_valid = 1'b0;   // PREP
    @(negedge Clk);                     // START
    @(negedge Clk);                     // WAIT
    Reset_n = 1'b0;
    #1;
    check_val("async_reset_outputs",
              {req_ready, resp_valid, dp_run, dp_div, resp_data, dp_opA, dp_opB}, '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_val("post_reset_wait_dp", req_ready, 1'b0);
  endtask

  initial begin
    #2 Reset_n = 1'b0;
    #1;
    check_val("reset_outputs",
              {req_ready, resp_valid, dp_run, dp_div, resp_data, dp_opA, dp_opB}, '0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    do_op(OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1);
    do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1);
    do_op(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, -1, 1);
    do_op(OP_REM,   32'hFFFF_FFF9, 32'd2, 0, -1, 1);
    do_op(OP_DIVU,  32'hFFFF_FFF9, 32'd2, 0, -1, 1);
    do_op(OP_DIVU,  32'h1234_5678, 32'd0, 0, 2, 0);
    do_op(OP_REM,   32'd5, 32'd0, 0, 2, 0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 2, 0);
    do_op(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0, 2, 0);
    do_op(OP_MULHSU, 32'hFFFF_FFFE, 32'h8000_0003, 0, -1, 1);
    do_op(OP_REM,   32'd17, 32'hFFFF_FFFB, 0, -1, 1);
    do_op(OP_REMU,  32'h8000_0001, 32'd10, 0, -1, 1);
    do_op(OP_DIV,   32'h8000_0000, 32'd3, 0, -1, 1);

    do_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5, -1, 1);
`ifdef MDU_OPCACHE_EN
    do_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 0, 2, 0);
`else
    do_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 0, -1, 1);
`endif

    for (int i = 0; i < 16; i++)
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, 0, -1, -1);

    kill_test();
    do_op(OP_MULHU, 32'hCAFE_F00D, 32'h0BAD_BEEF, 0, -1, 1);
    reset_test();
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, -1, 1);

    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_sequencer.md
# mdu_sequencer

Sequencer for the shared 33-bit shift-add multiply / restoring-divide datapath, executing the eight RV32M operations. It decodes funct3, sign-extends or takes magnitudes of the operands, runs the datapath, and applies quotient/remainder sign correction. It short-circuits divide-by-zero and signed overflow without using the datapath. It sits between the execute stage (valid/ready request and response) and the datapath's Run/div/ready ports.

## Interface
- No parameters. Data width is fixed at XLEN=32; the datapath width is 33.
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; reset 0
- funct3  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1, rs2  in  32  operands
- kill  in  1  synchronous abort of the in-flight op
- resp_valid  out  1  result present; reset 0
- resp_ready  in  1  consumer accepts
- resp_data  out  32  result; reset 0
- dp_run  out  1  one-cycle start pulse to the datapath; reset 0
- dp_div  out  1  0 = multiply, 1 = divide; held for the whole op; reset 0
- dp_opA, dp_opB  out  33  multiply: multiplicand, multiplier; divide: dividend, divisor; reset 0
- dp_Aval, dp_Bval  in  33  multiply: {Aval,Bval} is the 66-bit signed product; divide: Bval = quotient, Aval = remainder (unsigned)
- dp_ready  in  1  datapath idle/done

## Operation
- States are IDLE, PREP, START, WAIT, FIX, RESP and DRAIN.
- IDLE:
  - req_ready = dp_ready.
  - On accept, latch funct3, rs1 and rs2, then go to PREP.
- PREP (1 cycle):
  - MUL and MULH: both operands sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both zero-extended.
  - DIV and REM: operands are zero-extended magnitudes; record neg_q = s1^s2 and neg_r = s1.
  - DIVU and REMU: operands zero-extended, no negation.
  - If rs2 == 0 on a divide op, go to RESP with DIV/DIVU = 0xFFFFFFFF and REM/REMU = rs1.
  - If signed op with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF, go to RESP with DIV = 0x80000000 and REM = 0.
  - Otherwise go to START.
- START (1 cycle): dp_run = 1, then go to WAIT.
- WAIT: ignore dp_ready for 1 cycle after START, then go to FIX on the first dp_ready = 1.
- FIX (1 cycle): select the result.
  - MUL = Bval[31:0].
  - MULH/MULHSU/MULHU = {Aval[30:0], Bval[32]}.
  - DIV/DIVU = Bval[31:0], negated if neg_q.
  - REM/REMU = Aval[31:0], negated if neg_r.
  - Then go to RESP.
- RESP:
  - resp_valid = 1, with resp_data held stable.
  - On resp_ready, go to IDLE.
- kill:
  - In PREP, START, FIX or RESP: go to IDLE; resp_valid drops next cycle.
  - In WAIT: go to DRAIN, which waits for dp_ready = 1 and then returns to IDLE with no response.
  - kill takes priority over resp_ready in the same cycle.
- Arithmetic is two's complement, mod 2^32. |0x80000000| = 0x80000000 fits in 33 bits unsigned.

## Timing
- Latency from accept to resp_valid:
  - Bypass cases: 2 cycles.
  - Datapath ops: 4 + datapath cycles.
- No back-to-back accept: req_ready is 0 from the cycle after accept through the response handshake.
- Reset mid-operation:
  - All state returns to IDLE and all outputs go to their reset values.
  - The datapath is not reset by this block. Because req_ready follows dp_ready, new ops wait for the datapath to finish its own run.
- dp_opA, dp_opB and dp_div stay stable from PREP through WAIT.

## Configuration
- MDU_OPCACHE_EN defined:
  - A one-entry cache holds {funct3, rs1, rs2, result}, plus a valid bit that resets to 0.
  - A PREP hit goes directly to RESP with the cached result and does not touch the datapath.
  - The entry is written on FIX.
  - The valid bit is cleared on reset and on kill.
- MDU_OPCACHE_EN undefined: no cache logic is built, and every non-bypass op runs the datapath.

## Structure
- Package mdu_pkg holds:
  - the funct3 enum mdu_op_e;
  - the state enum mdu_state_e;
  - constants XLEN = 32, DPW = 33, DIV_OVF_Q = 32'h80000000.
- Sub-module mdu_result_fix: combinational result selection and conditional negation (FIX-state logic). It is reused by the cache path.

## Test plan
- MULH, rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF -> resp_data = 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MUL -> 0x00000001.
- DIV, rs1 = -7 (0xFFFFFFF9), rs2 = 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with the same operands -> 0x7FFFFFFC.
- DIVU, rs2 = 0 -> 0xFFFFFFFF after 2 cycles with dp_run never asserted; REM with rs1 = 5, rs2 = 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both with no dp_run.
- kill during WAIT -> DRAIN, no resp_valid, req_ready stays 0 until dp_ready returns; Reset_n low during WAIT -> all outputs 0 asynchronously.
- resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable, req_ready 0; with MDU_OPCACHE_EN, repeating the identical MUL -> response 2 cycles after accept and no dp_run.
